// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared request types and widths for the GCD request path
//
// Purpose: defines the packed operand-pair image carried on the request stream
//          and the canonical request width.
// Contents:
//   gcd_req_s         packed {a[31:0], b[31:0]}, bit-identical to data_i
//   gcd_req_width_gp  request width in bits (64)
package gcd_pkg;

  localparam int gcd_req_width_gp = 64;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } gcd_req_s;

endpackage

// File: rtl/gcd_req_buffer_ptr.sv
// rtl/gcd_req_buffer_ptr.sv - wrapping FIFO pointer
//
// Purpose: modulo-els_p counter used for the buffer's write and read pointers.
// Ports:
//   clk_i    in   clock, state on posedge
//   reset_i  in   asynchronous active-high reset, clears the pointer to 0
//   en_i     in   advance the pointer this cycle
//   ptr_o    out  current pointer value, $clog2(els_p) bits
module gcd_req_buffer_ptr #(
  parameter int els_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  output logic [$clog2(els_p)-1:0] ptr_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_o <= '0;
    end else if (en_i) begin
      // Explicit wrap keeps the counter correct even if els_p is not 2^n.
      ptr_o <= (ptr_o == last_lp) ? '0 : ptr_o + ptr_w_lp'(1);
    end
  end

endmodule

// File: rtl/gcd_req_buffer.sv
// rtl/gcd_req_buffer.sv - elastic request FIFO between trace source and GCD core
//
// Purpose: circular FIFO of els_p operand pairs; absorbs source requests while
//          the GCD core is busy and presents them in arrival order.
// Optional feature: GCD_REQ_BUFFER_STATS_EN adds a 16-bit wrapping count of
//          accepted requests on accepted_o.
// Ports:
//   clk_i       in   clock, state on posedge
//   reset_i     in   asynchronous active-high reset
//   v_i         in   source request valid
//   data_i      in   request payload {a, b}
//   yumi_o      out  request consumed this cycle (v_i & ~full, gated by reset)
//   v_o         out  head entry valid toward the core
//   data_o      out  head entry payload
//   ready_i     in   core accepts the head entry this cycle
//   accepted_o  out  total accepted requests (GCD_REQ_BUFFER_STATS_EN only)
//   count_o     out  current occupancy
module gcd_req_buffer
  import gcd_pkg::*;
#(
  parameter int width_p = gcd_req_width_gp,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       yumi_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       ready_i,
`ifdef GCD_REQ_BUFFER_STATS_EN
  output logic [15:0]                accepted_o,
`endif
  output logic [$clog2(els_p+1)-1:0] count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] wr_ptr;
  logic [ptr_w_lp-1:0] rd_ptr;
  logic [cnt_w_lp-1:0] count;
  logic                full;
  logic                empty;
  logic                enq;
  logic                deq;

  assign full  = (count == full_lp);
  assign empty = (count == '0);

  // No look-ahead on ready_i: a full FIFO refuses even when draining, so the
  // core's ready never reaches the source's yumi combinationally.
  assign enq    = v_i & ~full & ~reset_i;
  assign yumi_o = enq;

  assign v_o     = ~empty;
  assign deq     = v_o & ready_i;
  assign data_o  = mem[rd_ptr];
  assign count_o = count;

  gcd_req_buffer_ptr #(.els_p(els_p)) wr_ptr_u (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (enq),
    .ptr_o   (wr_ptr)
  );

  gcd_req_buffer_ptr #(.els_p(els_p)) rd_ptr_u (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (deq),
    .ptr_o   (rd_ptr)
  );

  // Storage is deliberately not reset; entries are only meaningful behind
  // count. enq is never true while full, so an occupied head is never hit.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count <= '0;
    end else begin
      case ({enq, deq})
        2'b10:   count <= count + cnt_w_lp'(1);
        2'b01:   count <= count - cnt_w_lp'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef GCD_REQ_BUFFER_STATS_EN
  logic [15:0] accepted;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      accepted <= '0;
    end else if (enq) begin
      accepted <= accepted + 16'd1;
    end
  end

  assign accepted_o = accepted;
`endif

endmodule

// File: tb/tb_gcd_req_buffer.sv
// tb/tb_gcd_req_buffer.sv - self-checking bench for gcd_req_buffer
module tb_gcd_req_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic [63:0] data_i;
  logic        yumi_o;
  logic        v_o;
  logic [63:0] data_o;
  logic        ready_i;
  logic [2:0]  count_o;
`ifdef GCD_REQ_BUFFER_STATS_EN
  logic [15:0] accepted_o;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: arrival-ordered queue of accepted payloads.
  logic [63:0] q[$];
  int          acc_model = 0;

  always #5 clk_i = ~clk_i;

  gcd_req_buffer #(.width_p(64), .els_p(4)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .yumi_o     (yumi_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .ready_i    (ready_i),
`ifdef GCD_REQ_BUFFER_STATS_EN
    .accepted_o (accepted_o),
`endif
    .count_o    (count_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive on negedge, check against the queue model, then let the
  // posedge happen and apply the FIFO rules to the model.
  task automatic cycle(input logic v, input logic [63:0] d, input logic r);
    logic exp_yumi;
    logic exp_v;
    @(negedge clk_i);
    v_i = v; data_i = d; ready_i = r;
    #1;
    exp_yumi = v && (q.size() < 4);
    exp_v    = (q.size() != 0);
    chk("model_yumi",  {63'd0, yumi_o}, {63'd0, exp_yumi});
    chk("model_v",     {63'd0, v_o},    {63'd0, exp_v});
    chk("model_count", {61'd0, count_o}, 64'(q.size()));
    if (exp_v) chk("model_data", data_o, q[0]);
`ifdef GCD_REQ_BUFFER_STATS_EN
    chk("model_accepted", {48'd0, accepted_o}, 64'(acc_model & 16'hFFFF));
`endif
    @(posedge clk_i);
    if (exp_v && r) void'(q.pop_front());
    if (exp_yumi) begin
      q.push_back(d);
      acc_model++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1; v_i = 1'b1; ready_i = 1'b0;
    #1;
    chk("reset_v",     {63'd0, v_o},    64'd0);
    chk("reset_yumi",  {63'd0, yumi_o}, 64'd0);
    chk("reset_count", {61'd0, count_o}, 64'd0);
`ifdef GCD_REQ_BUFFER_STATS_EN
    chk("reset_accepted", {48'd0, accepted_o}, 64'd0);
`endif
    q.delete();
    acc_model = 0;
    @(negedge clk_i);
    reset_i = 1'b0; v_i = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        r;
    logic        ey;
    logic        ev;
    logic [63:0] ed;
    int          ec;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [63:0] head;
    logic [63:0] fresh;

    // Hand-derived expectations: outputs seen before the edge of each row.
    tbl[0]  = '{1'b1, 64'h0000000C_00000012, 1'b1, 1'b1, 1'b0, 64'h0, 0};
    tbl[1]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h0000000C_00000012, 1};
    tbl[2]  = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 0};
    tbl[3]  = '{1'b1, 64'h1, 1'b0, 1'b1, 1'b0, 64'h0, 0};
    tbl[4]  = '{1'b1, 64'h2, 1'b0, 1'b1, 1'b1, 64'h1, 1};
    tbl[5]  = '{1'b1, 64'h3, 1'b0, 1'b1, 1'b1, 64'h1, 2};
    tbl[6]  = '{1'b1, 64'h4, 1'b0, 1'b1, 1'b1, 64'h1, 3};
    tbl[7]  = '{1'b1, 64'h5, 1'b0, 1'b0, 1'b1, 64'h1, 4};
    tbl[8]  = '{1'b1, 64'h5, 1'b1, 1'b0, 1'b1, 64'h1, 4};  // full + dequeue: refused
    tbl[9]  = '{1'b1, 64'h5, 1'b1, 1'b1, 1'b1, 64'h2, 3};  // freed slot used, count holds
    tbl[10] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h3, 3};
    tbl[11] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h4, 2};
    tbl[12] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h5, 1};
    tbl[13] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 0};

    reset_i = 1'b1; v_i = 1'b0; data_i = '0; ready_i = 1'b0;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      @(negedge clk_i);
      v_i = tbl[i].v; data_i = tbl[i].d; ready_i = tbl[i].r;
      #1;
      chk($sformatf("tbl%0d_yumi", i),  {63'd0, yumi_o},  {63'd0, tbl[i].ey});
      chk($sformatf("tbl%0d_v", i),     {63'd0, v_o},     {63'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_count", i), {61'd0, count_o}, 64'(tbl[i].ec));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), data_o, tbl[i].ed);
      @(posedge clk_i);
      if (tbl[i].ev && tbl[i].r) void'(q.pop_front());
      if (tbl[i].ey) begin
        q.push_back(tbl[i].d);
        acc_model++;
      end
    end

    // Stall hold: head must not move while the core stalls and new data arrives.
    do_reset();
    head = 64'hDEAD_BEEF_0000_0001;
    cycle(1'b1, head, 1'b0);
    for (int i = 0; i < 10; i++) begin
      fresh = {$urandom, $urandom};
      cycle(1'b1, fresh, 1'b0);
      chk("hold_v",    {63'd0, v_o}, 64'd1);
      chk("hold_data", data_o, head);
    end

    // Reset mid-operation, asserted between edges.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'hA0 + 64'(i), 1'b0);
    @(negedge clk_i);
    v_i = 1'b1; ready_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    chk("midrst_v",     {63'd0, v_o},    64'd0);
    chk("midrst_count", {61'd0, count_o}, 64'd0);
    chk("midrst_yumi",  {63'd0, yumi_o}, 64'd0);
    q.delete();
    acc_model = 0;
    @(negedge clk_i);
    reset_i = 1'b0; v_i = 1'b0;
    cycle(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1);
    cycle(1'b0, 64'h0, 1'b1);
    cycle(1'b0, 64'h0, 1'b1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
            1'($urandom_range(0, 2) != 0));
    end

`ifdef GCD_REQ_BUFFER_STATS_EN
    // Counter wrap: 65537 accepted requests leave accepted_o at 1.
    do_reset();
    @(negedge clk_i);
    v_i = 1'b1; ready_i = 1'b1;
    repeat (65537) @(negedge clk_i);
    v_i = 1'b0;
    #1;
    chk("stats_wrap", {48'd0, accepted_o}, 64'd1);
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
